// File: rtl/mix_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mix_meas_ctrl
// Brief    : Measurement sequencer for the I/Q mixer/accumulator datapath.
//            Runs a loopback measurement then an AD measurement. Partial
//            accumulation windows are discarded after every reconfiguration.
//            acc_shift is auto-ranged on overflow, so both result pairs are
//            captured with one common shift.
// Revision : 1.0 - initial release
// ============================================================================
module mix_meas_ctrl #(
    parameter int TO_W      = 24,
    parameter int SHIFT_MAX = 15
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  cfg_shift_init,
    input  logic [3:0]  cfg_discard,
    input  logic        res_valid,
    input  logic [31:0] ipcm_acc_in,
    input  logic [31:0] qpcm_acc_in,
    input  logic [1:0]  err_in,
    output logic        choose_lb,
    output logic [3:0]  acc_shift,
    output logic        err_clr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] lb_i,
    output logic [31:0] lb_q,
    output logic [31:0] ad_i,
    output logic [31:0] ad_q
);

    localparam logic [3:0]      C_SHIFT_MAX = 4'(SHIFT_MAX);
    // One below all-ones: the step that would make the watchdog saturate.
    localparam logic [TO_W-1:0] C_WD_LAST   = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [TO_W-1:0] C_WD_ONE    = {{(TO_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] C_ST_OK      = 2'd0;
    localparam logic [1:0] C_ST_RANGE   = 2'd1;
    localparam logic [1:0] C_ST_TIMEOUT = 2'd2;
    localparam logic [1:0] C_ST_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_SETTLE = 3'd2,
        S_MEAS   = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t            state_q,  state_d;
    logic              choose_lb_q, choose_lb_d;
    logic [3:0]        shift_q,  shift_d;
    logic              phase_ad_q, phase_ad_d;   // 0 = loopback, 1 = AD
    logic [3:0]        disc_q,   disc_d;
    logic [TO_W-1:0]   wd_q,     wd_d;
    logic [1:0]        status_q, status_d;
    logic [31:0]       lb_i_q, lb_i_d, lb_q_q, lb_q_d;
    logic [31:0]       ad_i_q, ad_i_d, ad_q_q, ad_q_d;

    // State and datapath-control registers with synchronous reset.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= S_IDLE;
            choose_lb_q <= 1'b0;
            shift_q     <= 4'd0;
            phase_ad_q  <= 1'b0;
            disc_q      <= 4'd0;
            wd_q        <= '0;
            status_q    <= C_ST_OK;
            lb_i_q      <= 32'd0;
            lb_q_q      <= 32'd0;
            ad_i_q      <= 32'd0;
            ad_q_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            choose_lb_q <= choose_lb_d;
            shift_q     <= shift_d;
            phase_ad_q  <= phase_ad_d;
            disc_q      <= disc_d;
            wd_q        <= wd_d;
            status_q    <= status_d;
            lb_i_q      <= lb_i_d;
            lb_q_q      <= lb_q_d;
            ad_i_q      <= ad_i_d;
            ad_q_q      <= ad_q_d;
        end
    end

    // Next-state logic: sequencing, discard counting, auto-ranging, watchdog.
    always_comb begin
        state_d     = state_q;
        choose_lb_d = choose_lb_q;
        shift_d     = shift_q;
        phase_ad_d  = phase_ad_q;
        disc_d      = disc_q;
        wd_d        = wd_q;
        status_d    = status_q;
        lb_i_d      = lb_i_q;
        lb_q_d      = lb_q_q;
        ad_i_d      = ad_i_q;
        ad_q_d      = ad_q_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_CLR;
                    shift_d     = cfg_shift_init;
                    choose_lb_d = 1'b1;
                    phase_ad_d  = 1'b0;
                end
            end

            S_CLR: begin
                disc_d = cfg_discard;
                wd_d   = '0;
                if (abort) begin
                    status_d = C_ST_ABORT;
                    state_d  = S_FIN;
                end else if (cfg_discard == 4'd0) begin
                    state_d = S_MEAS;
                end else begin
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE, S_MEAS: begin
                if (abort) begin
                    status_d = C_ST_ABORT;
                    state_d  = S_FIN;
                end else if (res_valid) begin
                    wd_d = '0;
                    if (state_q == S_SETTLE) begin
                        // Windows straddling the reconfiguration are dropped.
                        disc_d = disc_q - 4'd1;
                        if (disc_q <= 4'd1) begin
                            state_d = S_MEAS;
                        end
                    end else if (err_in != 2'b00) begin
                        if (shift_q < C_SHIFT_MAX) begin
                            // Restart from loopback so both phases share one shift.
                            shift_d     = shift_q + 4'd1;
                            choose_lb_d = 1'b1;
                            phase_ad_d  = 1'b0;
                            state_d     = S_CLR;
                        end else begin
                            status_d = C_ST_RANGE;
                            state_d  = S_FIN;
                        end
                    end else if (!phase_ad_q) begin
                        lb_i_d      = ipcm_acc_in;
                        lb_q_d      = qpcm_acc_in;
                        choose_lb_d = 1'b0;
                        phase_ad_d  = 1'b1;
                        state_d     = S_CLR;
                    end else begin
                        ad_i_d   = ipcm_acc_in;
                        ad_q_d   = qpcm_acc_in;
                        status_d = C_ST_OK;
                        state_d  = S_FIN;
                    end
                end else begin
                    wd_d = wd_q + C_WD_ONE;
                    if (wd_q == C_WD_LAST) begin
                        status_d = C_ST_TIMEOUT;
                        state_d  = S_FIN;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err_clr   = (state_q == S_CLR);
    assign busy      = (state_q == S_CLR) || (state_q == S_SETTLE) || (state_q == S_MEAS);
    assign done      = (state_q == S_FIN);
    assign choose_lb = choose_lb_q;
    assign acc_shift = shift_q;
    assign status    = status_q;
    assign lb_i      = lb_i_q;
    assign lb_q      = lb_q_q;
    assign ad_i      = ad_i_q;
    assign ad_q      = ad_q_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_meas_ctrl
// Brief    : Scoreboard bench for mix_meas_ctrl. The driver feeds randomized
//            res_valid pulses through a rule-level reference model and queues
//            the expected outcome; a monitor compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_meas_ctrl;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  cfg_shift_init = 4'd0;
    logic [3:0]  cfg_discard = 4'd0;
    logic        res_valid = 1'b0;
    logic [31:0] ipcm_acc_in = 32'd0;
    logic [31:0] qpcm_acc_in = 32'd0;
    logic [1:0]  err_in = 2'd0;
    logic        choose_lb, err_clr, busy, done;
    logic [3:0]  acc_shift;
    logic [1:0]  status;
    logic [31:0] lb_i, lb_q, ad_i, ad_q;

    mix_meas_ctrl #(.TO_W(4), .SHIFT_MAX(15)) dut (
        .clk1(clk1), .rst(rst), .start(start), .abort(abort),
        .cfg_shift_init(cfg_shift_init), .cfg_discard(cfg_discard),
        .res_valid(res_valid), .ipcm_acc_in(ipcm_acc_in), .qpcm_acc_in(qpcm_acc_in),
        .err_in(err_in), .choose_lb(choose_lb), .acc_shift(acc_shift),
        .err_clr(err_clr), .busy(busy), .done(done), .status(status),
        .lb_i(lb_i), .lb_q(lb_q), .ad_i(ad_i), .ad_q(ad_q)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] lb_i, lb_q, ad_i, ad_q;
        logic [3:0]  shift;
        logic        clb;
        int          nclr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   clr_seen = 0;

    // Reference model: measurement rules expressed as plain bookkeeping.
    int          m_shift, m_skip, m_disc, m_nclr;
    bit          m_in_ad, m_clb;
    logic [1:0]  m_status = 2'd0;
    logic [31:0] m_lb_i = 0, m_lb_q = 0, m_ad_i = 0, m_ad_q = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_begin(input int init, input int disc);
        m_shift = init; m_disc = disc; m_skip = disc;
        m_in_ad = 1'b0; m_clb = 1'b1; m_nclr = 1;
    endtask

    task automatic m_pulse(input logic [31:0] i, input logic [31:0] q,
                           input logic [1:0] err, output bit fin);
        fin = 1'b0;
        if (m_skip > 0) begin
            m_skip--;
        end else if (err != 0) begin
            if (m_shift < 15) begin
                m_shift++; m_clb = 1'b1; m_in_ad = 1'b0;
                m_skip = m_disc; m_nclr++;
            end else begin
                m_status = 2'd1; fin = 1'b1;
            end
        end else if (!m_in_ad) begin
            m_lb_i = i; m_lb_q = q; m_clb = 1'b0; m_in_ad = 1'b1;
            m_skip = m_disc; m_nclr++;
        end else begin
            m_ad_i = i; m_ad_q = q; m_status = 2'd0; fin = 1'b1;
        end
    endtask

    task automatic push_exp(input logic [1:0] st);
        exp_t x;
        m_status = st;
        x.status = st; x.lb_i = m_lb_i; x.lb_q = m_lb_q; x.ad_i = m_ad_i; x.ad_q = m_ad_q;
        x.shift = 4'(m_shift); x.clb = m_clb; x.nclr = m_nclr;
        sb.push_back(x);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk1) begin
        if (rst) begin
            clr_seen = 0;
        end else begin
            if (err_clr === 1'b1) clr_seen++;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("status",    status,    e.status);
                    check("lb_i",      lb_i,      e.lb_i);
                    check("lb_q",      lb_q,      e.lb_q);
                    check("ad_i",      ad_i,      e.ad_i);
                    check("ad_q",      ad_q,      e.ad_q);
                    check("acc_shift", acc_shift, e.shift);
                    check("choose_lb", choose_lb, e.clb);
                    check("err_clr_count", clr_seen, e.nclr);
                end
                clr_seen = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // mode: 0 random errors, 1 no errors, 2 error on first AD capture, 3 err=2 always
    task automatic run_meas(input int init, input int disc, input int mode);
        bit fin;
        bit used;
        logic [1:0] ev;
        cfg_shift_init = 4'(init);
        cfg_discard    = 4'(disc);
        m_begin(init, disc);
        start = 1'b1;
        tick();
        start = 1'b0;
        fin = 1'b0;
        used = 1'b0;
        for (int p = 0; p < 300 && !fin; p++) begin
            repeat ($urandom_range(1, 6)) tick();
            ipcm_acc_in = $urandom;
            qpcm_acc_in = $urandom;
            case (mode)
                0: ev = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                1: ev = 2'd0;
                2: begin
                    ev = (m_in_ad && m_skip == 0 && !used) ? 2'd1 : 2'd0;
                    if (ev != 0) used = 1'b1;
                end
                default: ev = 2'd2;
            endcase
            err_in    = ev;
            start     = ($urandom_range(0, 3) == 0);
            res_valid = 1'b1;
            m_pulse(ipcm_acc_in, qpcm_acc_in, ev, fin);
            if (fin) push_exp(m_status);
            tick();
            res_valid = 1'b0; start = 1'b0; err_in = 2'd0;
        end
        if (!fin) begin
            n_tests++; n_fail++;
            $display("FAIL pulse_budget: got no completion expected completion at %0t", $time);
        end
        // Now in the done cycle: a start here must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_fin_ignored", busy, 1'b0);
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_choose_lb", choose_lb, 1'b0);
        check("rst_acc_shift", acc_shift, 4'd0);
        check("rst_busy",      busy,      1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_status",    status,    2'd0);
        check("rst_err_clr",   err_clr,   1'b0);
        check("rst_lb_i",      lb_i,      32'd0);
        check("rst_ad_q",      ad_q,      32'd0);
        tick();

        run_meas(4, 2, 1);      // nominal
        run_meas(4, 2, 2);      // auto-range retry from AD phase
        run_meas(15, 1, 3);     // range fail, results held
        run_meas(7, 0, 1);      // no discard
        for (int k = 0; k < 20; k++) begin
            run_meas($urandom_range(10, 15), $urandom_range(0, 3), 0);
        end

        // Watchdog: no res_valid after start.
        cfg_shift_init = 4'd6; cfg_discard = 4'd2;
        m_begin(6, 2);
        push_exp(2'd2);
        start = 1'b1; tick(); start = 1'b0;   // CLR
        tick();                               // first SETTLE cycle
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("timeout_latency", n, 15);
        tick(); tick();

        // Abort in SETTLE coinciding with res_valid; start while busy.
        cfg_shift_init = 4'd3; cfg_discard = 4'd3;
        m_begin(3, 3);
        start = 1'b1; tick(); start = 1'b0;   // CLR
        start = 1'b1; tick(); start = 1'b0;   // SETTLE, start ignored
        res_valid = 1'b1; abort = 1'b1; ipcm_acc_in = $urandom; qpcm_acc_in = $urandom;
        push_exp(2'd3);
        tick();
        res_valid = 1'b0; abort = 1'b0;
        check("abort_done_next", done, 1'b1);
        tick(); tick();

        // Abort in IDLE is ignored.
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_idle_busy", busy, 1'b0);
        tick();

        // Synchronous reset in the middle of a measurement.
        cfg_shift_init = 4'd9; cfg_discard = 4'd0;
        start = 1'b1; tick(); start = 1'b0;   // CLR
        tick();                               // MEAS
        rst = 1'b1; tick(); rst = 1'b0;
        m_lb_i = 0; m_lb_q = 0; m_ad_i = 0; m_ad_q = 0; m_status = 2'd0;
        check("mrst_choose_lb", choose_lb, 1'b0);
        check("mrst_acc_shift", acc_shift, 4'd0);
        check("mrst_busy",      busy,      1'b0);
        check("mrst_status",    status,    2'd0);
        check("mrst_lb_i",      lb_i,      m_lb_i);
        check("mrst_lb_q",      lb_q,      m_lb_q);
        check("mrst_ad_i",      ad_i,      m_ad_i);
        check("mrst_ad_q",      ad_q,      m_ad_q);
        repeat (5) tick();
        check("mrst_no_done",   done,      1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mix_meas_ctrl.md
Name: mix_meas_ctrl

Overview:
Measurement sequencer for the I/Q mixer/accumulator datapath. It runs a loopback measurement (choose_lb=1) and then an AD measurement (choose_lb=0), discarding partial accumulation windows after each reconfiguration. It auto-ranges acc_shift on accumulator overflow and returns both I/Q result pairs captured with one common shift. It sits between the register bank (start/config/status) and the mixer datapath (choose_lb, acc_shift, err_clr, results, err).

Parameters:
TO_W, 24, width of the watchdog counter; timeout after 2^TO_W-1 clk1 cycles with no res_valid.
SHIFT_MAX, 15, largest acc_shift the controller may program.

Ports:
clk1  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a measurement when idle, ignored when busy
abort  in  1  one-cycle pulse; terminates any measurement
cfg_shift_init  in  4  initial acc_shift
cfg_discard  in  4  res_valid pulses discarded after each (re)configuration (0 = none)
res_valid  in  1  one-cycle pulse: datapath I/Q accumulator outputs just updated
ipcm_acc_in  in  32  datapath I accumulator output
qpcm_acc_in  in  32  datapath Q accumulator output
err_in  in  2  datapath sticky overflow flags
choose_lb  out  1  datapath input select
acc_shift  out  4  datapath accumulator shift
err_clr  out  1  datapath error clear pulse
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
status  out  2  0 ok, 1 range fail, 2 timeout, 3 aborted; valid from done
lb_i, lb_q, ad_i, ad_q  out  32 each  captured results

Behaviour:
- Reset: state IDLE; choose_lb=0, acc_shift=0, err_clr=0, busy=0, done=0, status=0, all result registers 0, counters 0. A reset mid-measurement discards everything with no done pulse.
- Clock and reset: one clock, clk1; reset is synchronous and active-high.
- States: IDLE, CLR, SETTLE, MEAS, FIN.
- IDLE: on start, go to CLR on the next edge with acc_shift=cfg_shift_init, choose_lb=1, busy=1, phase=LB.
- CLR: err_clr=1 for exactly one cycle. Load discard_cnt=cfg_discard and clear the watchdog. Go to SETTLE, or go directly to MEAS if cfg_discard=0.
- SETTLE: each res_valid decrements discard_cnt. At the pulse where the count reaches 0, go to MEAS. err_in is ignored in this state.
- MEAS: on res_valid, sample err_in in the same cycle.
  - err_in != 0 and acc_shift < SHIFT_MAX: acc_shift+1, choose_lb=1, phase=LB, go to CLR. Any AD-phase result is discarded so both phases share one shift.
  - err_in != 0 and acc_shift == SHIFT_MAX: status=1, go to FIN.
  - err_in == 0, phase=LB: lb_i/lb_q <= inputs, choose_lb=0, phase=AD, go to CLR.
  - err_in == 0, phase=AD: ad_i/ad_q <= inputs, status=0, go to FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE. choose_lb, acc_shift and the results hold their values until the next start.
- Watchdog: counts clk1 cycles in SETTLE/MEAS and clears on every res_valid and in CLR. When it saturates at all-ones: status=2, go to FIN.
- Abort in any non-IDLE state: status=3, go to FIN on the next edge. Abort has priority over res_valid and the watchdog in the same cycle. Abort in IDLE is ignored.
- Start while busy is ignored. Start in the same cycle as done is ignored; the state is still FIN.
- Result registers update only when the capture condition holds and are otherwise never modified (not even on a range retry).
- choose_lb and acc_shift change only on the edge entering CLR, so the datapath is reconfigured before the one-cycle err_clr pulse.

Test Plan:
- Nominal: cfg_shift_init=4, cfg_discard=2, I/Q inputs change per pulse, err_in=0 -> 3 pulses per phase; lb = 3rd-pulse values, ad = 6th-pulse values, acc_shift=4, status=0, done once, err_clr pulsed twice.
- Auto-range: err_in=1 at the first AD MEAS pulse (cfg_shift_init=4) -> acc_shift=5, choose_lb returns to 1, LB is re-measured, final results use shift 5, status=0.
- Range fail: cfg_shift_init=15, err_in=2 held -> after the first MEAS pulse status=1, done, lb/ad keep their prior values, acc_shift=15.
- Timeout with TO_W=4 and no res_valid -> done 15 cycles after entering SETTLE, status=2.
- Abort in SETTLE in the same cycle as res_valid -> status=3, done next cycle, discard count ignored; start during busy is ignored.
- cfg_discard=0 -> CLR goes straight to MEAS and the first res_valid is captured. Sync reset mid-MEAS -> all outputs return to 0, no done pulse.
